// File: rtl/fwd_writeback_buffer.sv
// fwd_writeback_buffer: in-order register-write FIFO draining to the register file, with youngest-value forwarding lookups.
// Ports: clk_i/rst_i (sync active-high); push_valid_i/push_addr_i/push_data_i/push_ready_o (result-stage writes);
// wb_valid_o/wb_addr_o/wb_data_o/wb_ready_i (register-file drain); rd_addr_i -> fwd_hit_o/fwd_data_o (NUM_RD lookups);
// count_o (occupied entries).
module fwd_writeback_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int NUM_RD = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_valid_i,
  input  logic [ADDR_W-1:0]          push_addr_i,
  input  logic [DATA_W-1:0]          push_data_i,
  output logic                       push_ready_o,
  output logic                       wb_valid_o,
  output logic [ADDR_W-1:0]          wb_addr_o,
  output logic [DATA_W-1:0]          wb_data_o,
  input  logic                       wb_ready_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD-1:0]          fwd_hit_o,
  output logic [NUM_RD*DATA_W-1:0]   fwd_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  logic push_acc, push_st, pop;
  assign push_ready_o = cnt != CW'(DEPTH);
  assign wb_valid_o   = cnt != '0;
  assign wb_addr_o    = addr_q[rp];
  assign wb_data_o    = data_q[rp];
  assign count_o      = cnt;
  assign push_acc     = push_valid_i && push_ready_o;
  assign push_st      = push_acc && push_addr_i != '0;
  assign pop          = wb_valid_o && wb_ready_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push_st) begin
        addr_q[wp] <= push_addr_i;
        data_q[wp] <= push_data_i;
        wp         <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push_st) - CW'(pop);
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              h;
    logic [DATA_W-1:0] d;
    assign ra = rd_addr_i[k*ADDR_W +: ADDR_W];
    // Scan oldest to youngest so later matches override; the same-cycle push wins over all stored entries.
    always_comb begin
      h = 1'b0;
      d = '0;
      for (int j = 0; j < DEPTH; j++)
        if (CW'(j) < cnt && addr_q[rp + PW'(j)] == ra) begin
          h = 1'b1;
          d = data_q[rp + PW'(j)];
        end
      if (push_st && push_addr_i == ra) begin
        h = 1'b1;
        d = push_data_i;
      end
      if (ra == '0) begin
        h = 1'b0;
        d = '0;
      end
    end
    assign fwd_hit_o[k]                  = h;
    assign fwd_data_o[k*DATA_W +: DATA_W] = d;
  end
endmodule
